// File: rtl/alu_pkg.sv
// Shared constants for the BasicCPU ALU: default width, unit select and per-unit operation codes.
package alu_pkg;

    localparam int DATA_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        UNIT_AU   = 2'b00,
        UNIT_LU   = 2'b01,
        UNIT_SHU  = 2'b10,
        UNIT_RSVD = 2'b11
    } unit_e;

    localparam logic [2:0] AU_ADD   = 3'b000;
    localparam logic [2:0] AU_SUB   = 3'b001;
    localparam logic [2:0] AU_INC   = 3'b010;
    localparam logic [2:0] AU_DEC   = 3'b011;
    localparam logic [2:0] AU_NEG   = 3'b100;
    localparam logic [2:0] AU_RSUB  = 3'b101;
    localparam logic [2:0] AU_PASSA = 3'b110;
    localparam logic [2:0] AU_PASSB = 3'b111;

    localparam logic [1:0] LU_AND = 2'b00;
    localparam logic [1:0] LU_OR  = 2'b01;
    localparam logic [1:0] LU_XOR = 2'b10;
    localparam logic [1:0] LU_NOT = 2'b11;

    localparam logic SHU_SHL = 1'b0;
    localparam logic SHU_SHR = 1'b1;

endpackage

// File: rtl/alu_adder.sv
// Ripple-carry adder shared by every arithmetic operation of the ALU.
// ALU_OVERFLOW_FLAG_EN adds a two's-complement overflow output.
module alu_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
`ifdef ALU_OVERFLOW_FLAG_EN
    ,
    output logic         overflow
`endif
);

    always_comb begin
        logic c;
        c   = cin;
        sum = '0;
        for (int i = 0; i < W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

`ifdef ALU_OVERFLOW_FLAG_EN
    // Overflow: both inputs share a sign bit that the sum does not.
    assign overflow = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
`endif

endmodule

// File: rtl/alu_core.sv
// Registered single-cycle ALU (arithmetic, logic, shift units) for the BasicCPU datapath.
// ALU_OVERFLOW_FLAG_EN adds the registered overflow flag output V.
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [4:0]            opcode,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] S,
    output logic                  Cout,
    output logic                  Z,
    output logic                  N,
    output logic                  illegal
`ifdef ALU_OVERFLOW_FLAG_EN
    ,
    output logic                  V
`endif
);

    localparam int W = DATA_WIDTH;

    logic [W-1:0] addA, addB, addSum;
    logic         addCin, addCout;
    logic [W-1:0] nextS;
    logic         nextCout, nextIllegal;
    unit_e        unitSel;

    assign unitSel = unit_e'(opcode[4:3]);

    // Every AU operation is one adder pass with muxed operands and carry-in.
    always_comb begin
        addA   = A;
        addB   = '0;
        addCin = 1'b0;
        case (opcode[2:0])
            AU_ADD:  addB = B;
            AU_SUB:  begin addB = ~B; addCin = 1'b1; end
            AU_INC:  addCin = 1'b1;
            AU_DEC:  addB = '1;
            AU_NEG:  begin addA = ~A; addCin = 1'b1; end
            AU_RSUB: begin addA = B; addB = ~A; addCin = 1'b1; end
            default: ;
        endcase
    end

`ifdef ALU_OVERFLOW_FLAG_EN
    logic addOverflow, nextV;
`endif

    alu_adder #(.W(W)) u_adder (
        .a       (addA),
        .b       (addB),
        .cin     (addCin),
        .sum     (addSum),
        .cout    (addCout)
`ifdef ALU_OVERFLOW_FLAG_EN
        ,
        .overflow(addOverflow)
`endif
    );

    always_comb begin
        nextS       = '0;
        nextCout    = 1'b0;
        nextIllegal = 1'b0;
`ifdef ALU_OVERFLOW_FLAG_EN
        nextV       = 1'b0;
`endif
        case (unitSel)
            UNIT_AU: begin
                if (opcode[2:0] == AU_PASSA) begin
                    nextS = A;
                end else if (opcode[2:0] == AU_PASSB) begin
                    nextS = B;
                end else begin
                    nextS    = addSum;
                    nextCout = addCout;
`ifdef ALU_OVERFLOW_FLAG_EN
                    nextV    = addOverflow;
`endif
                end
            end
            UNIT_LU: begin
                case (opcode[1:0])
                    LU_AND:  nextS = A & B;
                    LU_OR:   nextS = A | B;
                    LU_XOR:  nextS = A ^ B;
                    default: nextS = ~A;
                endcase
            end
            UNIT_SHU: begin
                if (opcode[0] == SHU_SHL) begin
                    nextS    = {A[W-2:0], 1'b0};
                    nextCout = A[W-1];
                end else begin
                    nextS    = {1'b0, A[W-1:1]};
                    nextCout = A[0];
                end
            end
            default: nextIllegal = 1'b1;
        endcase
    end

    // Z and N come from the value being loaded so they always agree with S.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            S         <= '0;
            Cout      <= 1'b0;
            Z         <= 1'b0;
            N         <= 1'b0;
            illegal   <= 1'b0;
`ifdef ALU_OVERFLOW_FLAG_EN
            V         <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                S       <= nextS;
                Cout    <= nextCout;
                Z       <= (nextS == '0);
                N       <= nextS[W-1];
                illegal <= nextIllegal;
`ifdef ALU_OVERFLOW_FLAG_EN
                V       <= nextV;
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed plan vectors, async reset, then randomized
// operations against an arithmetic reference model. Honours ALU_OVERFLOW_FLAG_EN.
module tb_alu_core;

    localparam int W = 8;

    typedef struct packed {
        logic [7:0] s;
        logic       cout;
        logic       z;
        logic       n;
        logic       ill;
        logic       v;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [W-1:0] A, B;
    logic [4:0]   opcode;
    logic         out_valid;
    logic [W-1:0] S;
    logic         Cout, Z, N, illegal;
`ifdef ALU_OVERFLOW_FLAG_EN
    logic         V;
`endif

    int   checks = 0;
    int   passes = 0;
    exp_t held;

    alu_core #(.DATA_WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .A        (A),
        .B        (B),
        .opcode   (opcode),
        .out_valid(out_valid),
        .S        (S),
        .Cout     (Cout),
        .Z        (Z),
        .N        (N),
        .illegal  (illegal)
`ifdef ALU_OVERFLOW_FLAG_EN
        ,
        .V        (V)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on unsigned and signed readings of the operands.
    function automatic exp_t model(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   ua, ub, sa, sb, t;
        bit   arith;
        e     = '0;
        ua    = int'(a);
        ub    = int'(b);
        sa    = int'($signed(a));
        sb    = int'($signed(b));
        t     = 0;
        arith = 1'b0;
        case (op[4:3])
            2'b00: begin
                case (op[2:0])
                    3'd0: begin e.s = 8'(ua + ub); e.cout = (ua + ub) > 255; t = sa + sb; arith = 1'b1; end
                    3'd1: begin e.s = 8'(ua - ub); e.cout = (ua >= ub);      t = sa - sb; arith = 1'b1; end
                    3'd2: begin e.s = 8'(ua + 1);  e.cout = (ua == 255);     t = sa + 1;  arith = 1'b1; end
                    3'd3: begin e.s = 8'(ua - 1);  e.cout = (ua != 0);       t = sa - 1;  arith = 1'b1; end
                    3'd4: begin e.s = 8'(0 - ua);  e.cout = (ua == 0);       t = -sa;     arith = 1'b1; end
                    3'd5: begin e.s = 8'(ub - ua); e.cout = (ub >= ua);      t = sb - sa; arith = 1'b1; end
                    3'd6: e.s = a;
                    default: e.s = b;
                endcase
            end
            2'b01: begin
                case (op[1:0])
                    2'd0: e.s = a & b;
                    2'd1: e.s = a | b;
                    2'd2: e.s = a ^ b;
                    default: e.s = ~a;
                endcase
            end
            2'b10: begin
                if (op[0] == 1'b0) begin
                    e.s    = 8'(ua * 2);
                    e.cout = (ua >= 128);
                end else begin
                    e.s    = 8'(ua / 2);
                    e.cout = (ua % 2) == 1;
                end
            end
            default: e.ill = 1'b1;
        endcase
        e.v = arith && (t > 127 || t < -128);
        e.z = (e.s == 8'h00);
        e.n = (int'(e.s) >= 128);
        return e;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    endtask

    task automatic checkOutput(input logic expValid, input exp_t e);
        check("out_valid", {7'b0, out_valid}, {7'b0, expValid});
        check("S",         S,                 e.s);
        check("Cout",      {7'b0, Cout},      {7'b0, e.cout});
        check("Z",         {7'b0, Z},         {7'b0, e.z});
        check("N",         {7'b0, N},         {7'b0, e.n});
        check("illegal",   {7'b0, illegal},   {7'b0, e.ill});
`ifdef ALU_OVERFLOW_FLAG_EN
        check("V",         {7'b0, V},         {7'b0, e.v});
`endif
    endtask

    // Drive one cycle away from the edge, then sample just after the active edge.
    task automatic applyStimulus(input logic v, input logic [4:0] op,
                                 input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        in_valid = v;
        opcode   = op;
        A        = a;
        B        = b;
        @(posedge clk);
        #1;
        if (v) held = model(op, a, b);
        checkOutput(v, held);
    endtask

    function automatic logic [7:0] pickOperand();
        logic [7:0] corner [4];
        corner[0] = 8'h00;
        corner[1] = 8'h7F;
        corner[2] = 8'h80;
        corner[3] = 8'hFF;
        if ($urandom_range(3) == 0) return corner[$urandom_range(3)];
        return 8'($urandom);
    endfunction

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        opcode   = '0;
        held     = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput(1'b0, '0);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(1'b1, 5'b00000, 8'hF0, 8'h20);
        check("plan add S", S, 8'h10);
        applyStimulus(1'b1, 5'b00001, 8'h05, 8'h05);
        check("plan sub Z", {7'b0, Z}, 8'h01);
        applyStimulus(1'b1, 5'b00001, 8'h03, 8'h05);
        check("plan sub borrow S", S, 8'hFE);
        applyStimulus(1'b1, 5'b00010, 8'hFF, 8'h00);
        applyStimulus(1'b1, 5'b00011, 8'h00, 8'h00);
        check("plan dec S", S, 8'hFF);
        applyStimulus(1'b1, 5'b00100, 8'h01, 8'h00);
        applyStimulus(1'b1, 5'b01000, 8'hCA, 8'h0F);
        applyStimulus(1'b1, 5'b01001, 8'hCA, 8'h0F);
        applyStimulus(1'b1, 5'b01010, 8'hCA, 8'h0F);
        applyStimulus(1'b1, 5'b01011, 8'hCA, 8'h0F);
        check("plan not S", S, 8'h35);
        applyStimulus(1'b1, 5'b10000, 8'h81, 8'h00);
        applyStimulus(1'b1, 5'b10001, 8'h81, 8'h00);
        check("plan shr S", S, 8'h40);
        applyStimulus(1'b1, 5'b11000, 8'h5A, 8'hA5);
        check("plan reserved illegal", {7'b0, illegal}, 8'h01);
        applyStimulus(1'b0, 5'b00000, 8'h11, 8'h22);
        applyStimulus(1'b0, 5'b00000, 8'h33, 8'h44);
`ifdef ALU_OVERFLOW_FLAG_EN
        applyStimulus(1'b1, 5'b00000, 8'h7F, 8'h01);
        check("plan overflow V", {7'b0, V}, 8'h01);
`endif

        // Reset asserted between edges while in_valid is high must clear outputs at once.
        applyStimulus(1'b1, 5'b00000, 8'h12, 8'h34);
        #2;
        reset = 1'b1;
        #1;
        held = '0;
        checkOutput(1'b0, '0);
        @(posedge clk);
        #1;
        checkOutput(1'b0, '0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        held = model(5'b00000, 8'h12, 8'h34);
        checkOutput(1'b1, held);
        check("post-reset add S", S, 8'h46);

        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(3) != 0), 5'($urandom), pickOperand(), pickOperand());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- Registered single-cycle ALU for the BasicCPU datapath.
- Combines three function units (see Behaviour), selected by a 5-bit opcode:
  - arithmetic unit: add, subtract, increment/decrement, negate, pass-through
  - logic unit: AND, OR, XOR, NOT
  - shift unit: shift left or right by one bit
- Result and flags are registered once per accepted operation.
- Sits between the register-file read ports and the write-back/flag register.

Parameters:
- DATA_WIDTH, 8, operand/result width in bits (must be >= 2).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and opcode are valid this cycle.
- A  in  DATA_WIDTH  operand A.
- B  in  DATA_WIDTH  operand B.
- opcode  in  5  operation select; see Behaviour.
- out_valid  out  1  registered result and flags are valid.
- S  out  DATA_WIDTH  registered result.
- Cout  out  1  registered carry/shift-out flag.
- Z  out  1  registered zero flag: 1 when S == 0.
- N  out  1  registered negative flag: equals S[DATA_WIDTH-1].
- illegal  out  1  registered flag: the accepted opcode was in the reserved space.

Behaviour:
- Reset (asynchronous, active-high): S, Cout, Z, N, illegal and out_valid all clear to 0 immediately and stay 0 while reset is high.
- Latency is one cycle:
  - in_valid=1 at edge k loads the result and flags; out_valid=1 after edge k.
  - in_valid=0 at an edge sets out_valid=0; S and all flags hold their previous values.
- No back-pressure; a new operation may be accepted every cycle.
- Unit select, opcode[4:3]:
  - 00 = arithmetic unit (AU)
  - 01 = logic unit (LU)
  - 10 = shift unit (SHU)
  - 11 = reserved
- AU, opcode[2:0]. All operations are modulo 2^DATA_WIDTH.
  - 000 A+B. Cout = carry-out.
  - 001 A-B, computed as A+~B+1. Cout=1 means no borrow.
  - 010 A+1. Cout = carry-out.
  - 011 A-1, computed as A+all-ones. Cout=0 only when A==0.
  - 100 -A, computed as ~A+1. Cout=1 only when A==0.
  - 101 B-A, computed as B+~A+1. Cout=1 means no borrow.
  - 110 pass A. Cout=0.
  - 111 pass B. Cout=0.
- LU, opcode[1:0]; opcode[2] is ignored. Cout=0 for all LU operations.
  - 00 A&B
  - 01 A|B
  - 10 A^B
  - 11 ~A
- SHU, opcode[0]; opcode[2:1] are ignored. Operand B is ignored.
  - 0 logical left: S = {A[W-2:0],0}, Cout = A[W-1].
  - 1 logical right: S = {0,A[W-1:1]}, Cout = A[0].
- Reserved (opcode[4:3]=11): S=0, Cout=0, Z=1, N=0, illegal=1. out_valid still follows in_valid.
- illegal=0 for every non-reserved opcode.
- Z and N are derived from the value being loaded into S, so they are consistent with S in the same cycle.
- Reset mid-operation: any pending load is discarded; the first valid result appears one edge after the first in_valid=1 following reset release.

Optional Feature:
- Macro: ALU_OVERFLOW_FLAG_EN.
- When defined: adds output port V (1 bit, registered, reset 0).
  - V is the two's-complement overflow of the AU add/subtract forms: set when both adder inputs have the same sign and the sum sign differs.
  - Applies to opcodes 000, 001, 010, 011, 100 and 101, using the effective adder inputs (e.g. A and ~B for 001).
  - V=0 for pass, LU, SHU and reserved operations.
- When not defined: port V does not exist; no overflow logic is generated.

Decomposition:
- Shared package alu_pkg holds:
  - the DATA_WIDTH default
  - unit-select constants (UNIT_AU, UNIT_LU, UNIT_SHU, UNIT_RSVD)
  - AU, LU and SHU operation-code constants
- One natural sub-module: alu_adder, a DATA_WIDTH ripple-carry adder with inputs a, b, cin and outputs sum, cout (plus overflow under the macro).
  - Every AU operation maps onto alu_adder by muxing its inputs.
  - LU and SHU stay inline in alu_core.

Test Plan (DATA_WIDTH=8):
- Reset: assert reset mid-stream with in_valid=1 -> S, Cout, Z, N, illegal and out_valid all go to 0 immediately (asynchronously); the first valid result appears one edge after in_valid=1 following reset release.
- Arithmetic:
  - opcode 00000, A=8'hF0, B=8'h20 -> S=8'h10, Cout=1, Z=0, N=0.
  - opcode 00001, A=8'h05, B=8'h05 -> S=8'h00, Cout=1, Z=1.
  - opcode 00001, A=8'h03, B=8'h05 -> S=8'hFE, Cout=0, N=1.
- Increment/negate boundaries:
  - opcode 00010, A=8'hFF -> S=8'h00, Cout=1, Z=1.
  - opcode 00011, A=8'h00 -> S=8'hFF, Cout=0.
  - opcode 00100, A=8'h01 -> S=8'hFF.
- Logic, A=8'hCA, B=8'h0F:
  - opcode 01000 -> S=8'h0A
  - opcode 01001 -> S=8'hCF
  - opcode 01010 -> S=8'hC5
  - opcode 01011 -> S=8'h35
  - Cout=0 for all four.
- Shift, A=8'h81:
  - opcode 10000 -> S=8'h02, Cout=1.
  - opcode 10001 -> S=8'h40, Cout=1.
- Reserved and handshake:
  - opcode 11000 -> S=0, Z=1, illegal=1.
  - Then in_valid=0 for two cycles -> out_valid=0 and S held.
  - With ALU_OVERFLOW_FLAG_EN: opcode 00000, A=8'h7F, B=8'h01 -> S=8'h80, V=1.
